// File: rtl/branch_resolver_pkg.sv
// Shared definitions for the stage-4 branch resolver: word type, branch
// condition indices into the ALU compare flags, and resolver state encodings.
package branch_resolver_pkg;

    typedef logic [31:0] word;

    // Indices into the registered ALU compare flags.
    localparam logic [1:0] eq = 2'd0;
    localparam logic [1:0] ne = 2'd1;
    localparam logic [1:0] lt = 2'd2;
    localparam logic [1:0] ge = 2'd3;

    // Resolver states.
    typedef logic [1:0] state_t;
    localparam state_t IDLE     = 2'd0;
    localparam state_t REDIRECT = 2'd1;
    localparam state_t FLUSH    = 2'd2;

    // JALR targets always have bit 0 forced low.
    function automatic word jalr_align(input word addr);
        return addr & ~32'h1;
    endfunction

endpackage

// File: rtl/branch_resolver_target_calc.sv
// Combinational branch outcome: taken decision, target, corrected next PC,
// mispredict flag against the front-end prediction, and fall-through PC.
module branch_target_calc
    import branch_resolver_pkg::*;
(
    input  logic       is_branch,
    input  logic       is_jal,
    input  logic       is_jalr,
    input  logic [1:0] cond,
    input  logic [3:0] compare,
    input  word        eval,
    input  word        pc,
    input  word        imm,
    input  logic       pred_taken,
    input  word        pred_target,
    output word        actual_next,
    output logic       mispredict,
    output word        fall_through
);

    logic taken;
    word  target;

    // Outcome, target selection and prediction check.
    always_comb begin
        taken        = is_jal | is_jalr | (is_branch & compare[cond]);
        target       = is_jalr ? jalr_align(eval) : (pc + imm);
        fall_through = pc + 32'd4;
        actual_next  = taken ? target : fall_through;
        mispredict   = (pred_taken != taken) | (taken & (pred_target != target));
    end

endmodule

// File: rtl/branch_resolver.sv
// Stage-4 branch resolver: decides control-transfer outcome, offers a
// redirect to fetch on mispredict, then flushes FLUSH_DEPTH younger stages.
// Optional statistics counters are built when BRANCH_STATS_EN is defined.
module branch_resolver
    import branch_resolver_pkg::*;
#(
    parameter int unsigned FLUSH_DEPTH = 3
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        valid_in,
    input  logic        is_branch,
    input  logic        is_jal,
    input  logic        is_jalr,
    input  logic [1:0]  cond,
    input  logic [3:0]  compare,
    input  logic [31:0] eval,
    input  logic [31:0] pc,
    input  logic [31:0] imm,
    input  logic        pred_taken,
    input  logic [31:0] pred_target,
    input  logic        redirect_ready,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        flush,
    output logic        busy,
    output logic [31:0] link
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0] mispredict_count,
    output logic [31:0] resolved_count
`endif
);

    state_t     state;
    logic [2:0] flush_cnt;
    word        actual_next;
    word        fall_through;
    logic       mispredict;
    logic       accept;

    branch_target_calc u_calc (
        .is_branch    (is_branch),
        .is_jal       (is_jal),
        .is_jalr      (is_jalr),
        .cond         (cond),
        .compare      (compare),
        .eval         (eval),
        .pc           (pc),
        .imm          (imm),
        .pred_taken   (pred_taken),
        .pred_target  (pred_target),
        .actual_next  (actual_next),
        .mispredict   (mispredict),
        .fall_through (fall_through)
    );

    // Only real control transfers seen while idle are resolved; anything
    // arriving during redirect/flush is wrong-path.
    always_comb begin
        accept = valid_in & (state == IDLE) & (is_branch | is_jal | is_jalr);
    end

    // Resolver FSM: redirect handshake followed by a counted flush.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            redirect_pc <= '0;
            flush_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept && mispredict) begin
                        state       <= REDIRECT;
                        redirect_pc <= actual_next;
                    end
                end
                REDIRECT: begin
                    if (redirect_ready) begin
                        state     <= FLUSH;
                        flush_cnt <= 3'(FLUSH_DEPTH - 1);
                    end
                end
                FLUSH: begin
                    if (flush_cnt == 3'd0) begin
                        state <= IDLE;
                    end else begin
                        flush_cnt <= flush_cnt - 3'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Link value for JAL/JALR write-back, captured for every resolved transfer.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            link <= '0;
        end else if (accept) begin
            link <= fall_through;
        end
    end

`ifdef BRANCH_STATS_EN
    // Resolution and mispredict statistics, wrapping at 2^32.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            resolved_count   <= '0;
            mispredict_count <= '0;
        end else if (accept) begin
            resolved_count <= resolved_count + 32'd1;
            if (mispredict) begin
                mispredict_count <= mispredict_count + 32'd1;
            end
        end
    end
`endif

    // Status outputs decoded from the registered state.
    always_comb begin
        redirect_valid = (state == REDIRECT);
        flush          = (state == FLUSH);
        busy           = (state != IDLE);
    end

endmodule

// File: tb/tb_branch_resolver.sv
// Scoreboard bench for branch_resolver: expected redirect PCs are queued at
// issue time and checked by an independent monitor at each accepted redirect.
module tb_branch_resolver;
    import branch_resolver_pkg::*;

    localparam int unsigned FD = 3;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        valid_in = 1'b0;
    logic        is_branch = 1'b0, is_jal = 1'b0, is_jalr = 1'b0;
    logic [1:0]  cond = 2'd0;
    logic [3:0]  compare = 4'd0;
    logic [31:0] eval = '0, pc = '0, imm = '0, pred_target = '0;
    logic        pred_taken = 1'b0;
    logic        redirect_ready = 1'b0;
    logic        redirect_valid, flush, busy;
    logic [31:0] redirect_pc, link;
`ifdef BRANCH_STATS_EN
    logic [31:0] mispredict_count, resolved_count;
`endif

    int checks = 0;
    int failures = 0;
    word exp_q[$];

    int   fcnt = 0;
    logic prev_rv = 1'b0, prev_rdy = 1'b0;
    word  prev_pc = '0;

    branch_resolver #(.FLUSH_DEPTH(FD)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .valid_in       (valid_in),
        .is_branch      (is_branch),
        .is_jal         (is_jal),
        .is_jalr        (is_jalr),
        .cond           (cond),
        .compare        (compare),
        .eval           (eval),
        .pc             (pc),
        .imm            (imm),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .redirect_ready (redirect_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .flush          (flush),
        .busy           (busy),
        .link           (link)
`ifdef BRANCH_STATS_EN
        ,
        .mispredict_count (mispredict_count),
        .resolved_count   (resolved_count)
`endif
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic br, input logic jal, input logic jalr,
                         input logic [1:0] c, input logic [3:0] cmp,
                         input word ev, input word p, input word im,
                         input logic pt, input word ptg);
        is_branch   = br;
        is_jal      = jal;
        is_jalr     = jalr;
        cond        = c;
        compare     = cmp;
        eval        = ev;
        pc          = p;
        imm         = im;
        pred_taken  = pt;
        pred_target = ptg;
        valid_in    = 1'b1;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 50) begin
            step();
            n++;
        end
        if (busy) check(name, 32'(busy), 32'd0);
    endtask

    // Monitor: redirect scoreboard, redirect hold, flush pulse length.
    always @(negedge clock) begin
        if (!reset_n) begin
            fcnt     = 0;
            prev_rv  = 1'b0;
            prev_rdy = 1'b0;
        end else begin
            if (prev_rv && !prev_rdy) begin
                check("rv_hold", 32'(redirect_valid), 32'd1);
                check("rpc_hold", redirect_pc, prev_pc);
            end
            if (redirect_valid && redirect_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_redirect: got 0x%08h expected none", redirect_pc);
                end else begin
                    check("redirect_pc", redirect_pc, exp_q.pop_front());
                end
            end
            if (flush) begin
                fcnt++;
            end else if (fcnt != 0) begin
                check("flush_len", 32'(fcnt), FD);
                fcnt = 0;
            end
            prev_rv  = redirect_valid;
            prev_rdy = redirect_ready;
            prev_pc  = redirect_pc;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) step();
        check("rst_rv", 32'(redirect_valid), 32'd0);
        check("rst_flush", 32'(flush), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rpc", redirect_pc, 32'd0);
        check("rst_link", link, 32'd0);
        reset_n = 1'b1;
        step();

        // redirect_ready while idle has no effect
        redirect_ready = 1'b1;
        step();
        check("idle_ready_busy", 32'(busy), 32'd0);
        check("idle_ready_rv", 32'(redirect_valid), 32'd0);
        redirect_ready = 1'b0;

        // BEQ correctly predicted taken
        issue(1'b1, 1'b0, 1'b0, eq, 4'b0001, '0, 32'h100, 32'h20, 1'b1, 32'h120);
        step();
        valid_in = 1'b0;
        check("beq_link", link, 32'h104);
        check("beq_busy", 32'(busy), 32'd0);
        check("beq_rv", 32'(redirect_valid), 32'd0);

        // back-to-back correct JALs
        issue(1'b0, 1'b1, 1'b0, eq, 4'b0000, '0, 32'h140, 32'h10, 1'b1, 32'h150);
        step();
        check("b2b1_busy", 32'(busy), 32'd0);
        check("b2b1_link", link, 32'h144);
        issue(1'b0, 1'b1, 1'b0, eq, 4'b0000, '0, 32'h150, 32'h8, 1'b1, 32'h158);
        step();
        valid_in = 1'b0;
        check("b2b2_busy", 32'(busy), 32'd0);
        check("b2b2_link", link, 32'h154);

        // BLT taken, predicted not-taken
        issue(1'b1, 1'b0, 1'b0, lt, 4'b0100, '0, 32'h200, 32'hFFFF_FFF8, 1'b0, 32'h0);
        exp_q.push_back(32'h1F8);
        step();
        valid_in = 1'b0;
        check("blt_rv", 32'(redirect_valid), 32'd1);
        check("blt_rpc", redirect_pc, 32'h1F8);
        check("blt_busy", 32'(busy), 32'd1);
        check("blt_link", link, 32'h204);
        redirect_ready = 1'b1;
        step();
        redirect_ready = 1'b0;
        check("blt_acc_rv", 32'(redirect_valid), 32'd0);
        check("blt_acc_flush", 32'(flush), 32'd1);
        wait_idle("blt_idle");

        // JALR with odd eval: LSB cleared, matches prediction
        issue(1'b0, 1'b0, 1'b1, eq, 4'b0000, 32'h3001, 32'h400, 32'h55, 1'b1, 32'h3000);
        step();
        valid_in = 1'b0;
        check("jalr_rv", 32'(redirect_valid), 32'd0);
        check("jalr_busy", 32'(busy), 32'd0);
        check("jalr_link", link, 32'h404);

        // JAL mispredict, fetch stalls 5 cycles, wrong-path valid_in throughout
        issue(1'b0, 1'b1, 1'b0, eq, 4'b0000, '0, 32'h500, 32'h40, 1'b0, 32'h0);
        exp_q.push_back(32'h540);
        step();
        check("jal_rv", 32'(redirect_valid), 32'd1);
        issue(1'b1, 1'b0, 1'b0, eq, 4'b0001, '0, 32'h900, 32'h4, 1'b0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_rv", 32'(redirect_valid), 32'd1);
            check("stall_rpc", redirect_pc, 32'h540);
            check("stall_link", link, 32'h504);
        end
        redirect_ready = 1'b1;
        step();
        redirect_ready = 1'b0;
        check("jal_acc_flush", 32'(flush), 32'd1);
        begin
            int n = 0;
            while (busy && n < 20) begin
                step();
                n++;
            end
        end
        valid_in = 1'b0;
        check("jal_end_busy", 32'(busy), 32'd0);
        check("wrongpath_link", link, 32'h504);

        // BNE not taken, predicted taken; reset during flush
        issue(1'b1, 1'b0, 1'b0, ne, 4'b0000, '0, 32'h600, 32'h40, 1'b1, 32'h640);
        exp_q.push_back(32'h604);
        step();
        valid_in = 1'b0;
        check("bne_rv", 32'(redirect_valid), 32'd1);
        check("bne_rpc", redirect_pc, 32'h604);
        redirect_ready = 1'b1;
        step();
        redirect_ready = 1'b0;
        check("bne_flush", 32'(flush), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("mrst_flush", 32'(flush), 32'd0);
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_rv", 32'(redirect_valid), 32'd0);
        check("mrst_rpc", redirect_pc, 32'd0);
        check("mrst_link", link, 32'd0);
        step();
        reset_n = 1'b1;
        step();
        issue(1'b1, 1'b0, 1'b0, ge, 4'b1000, '0, 32'h700, 32'h10, 1'b1, 32'h710);
        step();
        valid_in = 1'b0;
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_rv", 32'(redirect_valid), 32'd0);
        check("post_rst_link", link, 32'h704);

`ifdef BRANCH_STATS_EN
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        step();
        check("stats_rst_res", resolved_count, 32'd0);
        check("stats_rst_mis", mispredict_count, 32'd0);
        for (int i = 0; i < 10; i++) begin
            logic mis;
            word  p;
            mis = (i == 2) || (i == 5) || (i == 8);
            p   = 32'h1000 + 32'(i) * 32'h10;
            issue(1'b1, 1'b0, 1'b0, eq, 4'b0001, '0, p, 32'h8, !mis, p + 32'h8);
            if (mis) exp_q.push_back(p + 32'h8);
            step();
            valid_in = 1'b0;
            if (mis) begin
                redirect_ready = 1'b1;
                wait_idle("stats_idle");
                redirect_ready = 1'b0;
            end
        end
        check("stats_resolved", resolved_count, 32'd10);
        check("stats_mispredict", mispredict_count, 32'd3);
`endif

        repeat (2) step();
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/branch_resolver.md
# branch_resolver

Stage-4 consumer of the registered ALU results (`compare` flags, `eval`). It decides branch/jump outcome, compares it against the front-end prediction, and on mispredict drives a redirect handshake toward fetch plus a timed flush of the younger pipeline stages. It also produces the link value for JAL/JALR write-back.

## Interface
Parameters:
- FLUSH_DEPTH, 3, number of younger stages killed after a redirect is accepted (1..7)

Ports:
- clock  in  1  pipeline clock
- reset_n  in  1  asynchronous, active-low reset
- valid_in  in  1  control-transfer instruction present in stage 4 this cycle
- is_branch, is_jal, is_jalr  in  1 each  one-hot instruction kind; all-zero with valid_in is a non-transfer and is ignored
- cond  in  2  branch condition select, indexes `compare` via `eq`/`ne`/`lt`/`ge` from definitions.vh
- compare  in  4  registered ALU flags
- eval  in  word  registered ALU sum (JALR target = rs1+imm)
- pc, imm  in  word  instruction PC and decoded immediate
- pred_taken  in  1  front-end prediction
- pred_target  in  word  predicted target
- redirect_ready  in  1  fetch accepts redirect
- redirect_valid  out  1  redirect offered
- redirect_pc  out  word  corrected next PC
- flush  out  1  kill younger stages
- busy  out  1  resolver not in IDLE; upstream stalls stage 4
- link  out  word  pc+4, registered
- mispredict_count, resolved_count  out  32 each  only with BRANCH_STATS_EN

## Operation
- taken = is_jal | is_jalr | (is_branch & compare[cond]).
- target = pc+imm for branch/JAL; (eval & ~32'h1) for JALR. Sums are 32-bit modulo, no overflow detection.
- actual_next = taken ? target : pc+4.
- mispredict = (pred_taken != taken) | (taken & pred_target != target).
- States: IDLE, REDIRECT, FLUSH.
- IDLE: valid_in & mispredict -> REDIRECT, latch actual_next into redirect_pc. Otherwise stay.
- REDIRECT: redirect_valid=1, redirect_pc stable. redirect_ready -> FLUSH, load flush counter with FLUSH_DEPTH-1.
- FLUSH: flush=1; counter decrements each cycle; at 0 -> IDLE.
- valid_in outside IDLE is wrong-path: ignored, no stat update, no link update.
- link updates whenever valid_in in IDLE, regardless of mispredict.
- busy = (state != IDLE).

## Timing
- Reset (async assert, sync release): state IDLE; redirect_valid=0, flush=0, busy=0, redirect_pc=0, link=0, counters=0.
- Decision latency 1 cycle: valid_in at edge N -> redirect_valid high after edge N+1.
- redirect_valid never drops without redirect_ready; redirect_pc constant while valid.
- Accept at edge M -> flush high for exactly FLUSH_DEPTH cycles starting after M; redirect_valid low after M.
- redirect_ready while redirect_valid=0: no effect.
- Back-to-back correct predictions: resolved every cycle, never busy.
- Reset mid-REDIRECT/FLUSH: outputs cleared immediately, redirect lost.

## Configuration
- BRANCH_STATS_EN defined: 32-bit resolved_count increments per valid_in accepted in IDLE; mispredict_count per mispredict; both wrap at 2^32.
- Undefined: counter ports and logic absent; all other behaviour identical.

## Structure
- Shared package/definitions.vh: `word`, `eq`/`ne`/`lt`/`ge` indices, resolver state enum (IDLE, REDIRECT, FLUSH).
- One sub-module: `branch_target_calc` (combinational taken/target/actual_next/mispredict); FSM, handshake, counters in top.

## Test plan
- BEQ, compare=eq set, pc=0x100, imm=0x20, pred_taken=1, pred_target=0x120 -> no redirect, busy=0, link=0x104.
- BLT, lt set, pc=0x200, imm=-8, pred_taken=0 -> redirect_pc=0x1F8 one cycle later; flush 3 cycles after accept.
- JALR, eval=0x3001, pred_target=0x3000, pred_taken=1 -> no redirect (LSB cleared), link=pc+4.
- Mispredict with redirect_ready low 5 cycles, then high -> redirect_valid/pc held 5 cycles, FLUSH_DEPTH flush pulses, valid_in during all ignored.
- reset_n low during FLUSH -> flush, busy, redirect_valid 0 immediately; clean resolve after release.
- BRANCH_STATS_EN: 10 branches, 3 mispredicts -> resolved_count=10, mispredict_count=3.
